jpeg_strip_scheduler: RTL and testbench

Ping-pong controller for the 10-EBR strip buffer, organised as two banks of 5 EBRs, that sits between `hm01b0_ingester` and the JPEG encoder front end. When the ingester has written a complete 8-line strip, this block swaps banks by toggling `frontbuffer_select`. It then reads the finished bank out as forty 8x8 blocks over a valid/ready pixel stream. It also detects strips that arrive while the previous strip is still being read out.

---
 rtl/jfpjc_pkg.sv | 20 ++
 rtl/pixel_skid_buffer.sv | 65 ++++++
 rtl/jpeg_strip_scheduler.sv | 166 ++++++++++++++++
 tb/tb_jpeg_strip_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jfpjc_pkg.sv
// Shared constants, FSM state type and EBR address packing for the strip scheduler.
package jfpjc_pkg;

    localparam int PIXELS_PER_BLOCK = 64;
    localparam int STRIP_PIXELS     = 2560;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } sched_state_t;

    // row*64 + blk*8 + col, built by concatenation so no adder is needed.
    function automatic logic [8:0] pack_addr(input logic [2:0] row,
                                             input logic [2:0] blk,
                                             input logic [2:0] col);
        return {row, blk, col};
    endfunction

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry FIFO between the EBR read pipeline and the pixel stream; space_avail
// already accounts for the read whose data lands in the buffer on the next edge.
module pixel_skid_buffer #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             space_avail
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             push, pop;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
        end
    end

    // A read issued now is pushed one edge after the next, so room must exist after this edge.
    assign space_avail = (count_d < 2'd2);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (!nreset) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/jpeg_strip_scheduler.sv
// Ping-pong strip buffer controller: swaps banks on strip_done and streams the
// finished bank out as 8x8 blocks, counting strips that arrive while busy.
module jpeg_strip_scheduler
    import jfpjc_pkg::*;
#(
    parameter int NUM_EBRS       = 5,
    parameter int BLOCKS_PER_EBR = 8,
    parameter int ADDR_WIDTH     = 9
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  strip_done,
    output logic                  frontbuffer_select,
    output logic [2:0]            ebr_read_select,
    output logic [ADDR_WIDTH-1:0] ebr_raddr,
    output logic                  ebr_rclken,
    input  logic [7:0]            ebr_rdata,
    output logic [7:0]            pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  block_start,
    output logic                  strip_last,
    output logic                  busy,
    output logic                  overrun,
    output logic [7:0]            dropped_strips
);

    localparam logic [2:0] E_LAST = 3'(NUM_EBRS - 1);
    localparam logic [2:0] B_LAST = 3'(BLOCKS_PER_EBR - 1);

    sched_state_t state_q, state_d;
    logic         strip_done_q;
    logic         fb_q, fb_d;
    logic [2:0]   e_q, e_d, b_q, b_d, r_q, r_d, k_q, k_d;
    logic         rd_valid_q, rd_valid_d;
    logic [1:0]   rd_meta_q, rd_meta_d;
    logic         overrun_q, overrun_d;
    logic [7:0]   dropped_q, dropped_d;
    logic         space_avail, issue, last_addr, last_xfer, start, drop;
    logic [9:0]   skid_out;

    assign issue     = (state_q == ST_STREAM) && space_avail;
    assign last_addr = (e_q == E_LAST) && (b_q == B_LAST) && (r_q == 3'd7) && (k_q == 3'd7);
    assign last_xfer = pix_valid && pix_ready && strip_last;

    always_comb begin
        state_d   = state_q;
        fb_d      = fb_q;
        e_d       = e_q;
        b_d       = b_q;
        r_d       = r_q;
        k_d       = k_q;
        overrun_d = overrun_q;
        dropped_d = dropped_q;
        start     = 1'b0;
        drop      = 1'b0;

        // Loop nest e > b > r > k; advances only on an issued read.
        if (issue) begin
            k_d = k_q + 3'd1;
            if (k_q == 3'd7) begin
                r_d = r_q + 3'd1;
                if (r_q == 3'd7) begin
                    b_d = (b_q == B_LAST) ? 3'd0 : b_q + 3'd1;
                    if (b_q == B_LAST) begin
                        e_d = e_q + 3'd1;
                    end
                end
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                start = strip_done_q;
            end
            ST_STREAM: begin
                if (issue && last_addr) begin
                    state_d = ST_DRAIN;
                end
                drop = strip_done_q;
            end
            ST_DRAIN: begin
                if (last_xfer) begin
                    state_d = ST_IDLE;
                    start   = strip_done_q;
                end else begin
                    drop = strip_done_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d = ST_STREAM;
            fb_d    = ~fb_q;
            e_d     = 3'd0;
            b_d     = 3'd0;
            r_d     = 3'd0;
            k_d     = 3'd0;
        end

        // The ingester keeps overwriting the same fill bank for a dropped strip.
        if (drop) begin
            overrun_d = 1'b1;
            if (dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end
        end

        rd_valid_d = issue;
        rd_meta_d  = {issue && (r_q == 3'd0) && (k_q == 3'd0), issue && last_addr};
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            strip_done_q <= 1'b0;
            fb_q         <= 1'b0;
            e_q          <= 3'd0;
            b_q          <= 3'd0;
            r_q          <= 3'd0;
            k_q          <= 3'd0;
            rd_valid_q   <= 1'b0;
            rd_meta_q    <= 2'b00;
            overrun_q    <= 1'b0;
            dropped_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            strip_done_q <= strip_done;
            fb_q         <= fb_d;
            e_q          <= e_d;
            b_q          <= b_d;
            r_q          <= r_d;
            k_q          <= k_d;
            rd_valid_q   <= rd_valid_d;
            rd_meta_q    <= rd_meta_d;
            overrun_q    <= overrun_d;
            dropped_q    <= dropped_d;
        end
    end

    pixel_skid_buffer #(
        .WIDTH(10)
    ) u_skid (
        .clock      (clock),
        .nreset     (nreset),
        .in_valid   (rd_valid_q),
        .in_data    ({rd_meta_q, ebr_rdata}),
        .out_valid  (pix_valid),
        .out_data   (skid_out),
        .out_ready  (pix_ready),
        .space_avail(space_avail)
    );

    assign frontbuffer_select = fb_q;
    assign ebr_read_select    = e_q;
    assign ebr_raddr          = ADDR_WIDTH'(pack_addr(r_q, b_q, k_q));
    assign ebr_rclken         = issue;
    assign pix_data           = skid_out[7:0];
    assign block_start        = pix_valid && skid_out[9];
    assign strip_last         = pix_valid && skid_out[8];
    assign busy               = (state_q != ST_IDLE);
    assign overrun            = overrun_q;
    assign dropped_strips     = dropped_q;

endmodule

// File: tb/tb_jpeg_strip_scheduler.sv
// Directed bench for jpeg_strip_scheduler with a pixel scoreboard.
module tb_jpeg_strip_scheduler;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic       strip_done = 1'b0;
    logic       frontbuffer_select;
    logic [2:0] ebr_read_select;
    logic [8:0] ebr_raddr;
    logic       ebr_rclken;
    logic [7:0] ebr_rdata = 8'd0;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready = 1'b1;
    logic       block_start;
    logic       strip_last;
    logic       busy;
    logic       overrun;
    logic [7:0] dropped_strips;

    int tests = 0;
    int fails = 0;
    int rx_count = 0;
    bit rand_ready = 1'b0;
    logic [9:0] exp_q[$];

    always #5 clock = ~clock;

    jpeg_strip_scheduler dut (
        .clock(clock), .nreset(nreset), .strip_done(strip_done),
        .frontbuffer_select(frontbuffer_select), .ebr_read_select(ebr_read_select),
        .ebr_raddr(ebr_raddr), .ebr_rclken(ebr_rclken), .ebr_rdata(ebr_rdata),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .block_start(block_start), .strip_last(strip_last), .busy(busy),
        .overrun(overrun), .dropped_strips(dropped_strips)
    );

    function automatic logic [7:0] mem_val(input int e, input int a);
        return 8'((e * 37 + a) & 255);
    endfunction

    // EBR model: synchronous read, one cycle latency.
    always @(posedge clock) begin
        if (ebr_rclken) ebr_rdata <= mem_val(int'(ebr_read_select), int'(ebr_raddr));
    end

    // Scoreboard consumer: one line per mismatching transfer.
    always @(negedge clock) begin
        if (nreset && pix_valid && pix_ready) begin
            logic [9:0] expv;
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_pixel: observed=%0h expected=none", {block_start, strip_last, pix_data});
            end
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                tests++;
                assert ({block_start, strip_last, pix_data} === expv) else begin
                    fails++;
                    $error("FAIL pixel_%0d: observed=%0h expected=%0h", rx_count, {block_start, strip_last, pix_data}, expv);
                end
            end
            rx_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_strip();
        for (int e = 0; e < 5; e++)
            for (int b = 0; b < 8; b++)
                for (int r = 0; r < 8; r++)
                    for (int k = 0; k < 8; k++)
                        exp_q.push_back({(r == 0 && k == 0), (e == 4 && b == 7 && r == 7 && k == 7),
                                         mem_val(e, r * 64 + b * 8 + k)});
    endtask

    task automatic pulse_done();
        strip_done = 1'b1;
        step();
        strip_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_rx(input string tag, input int target, input int max);
        int n = 0;
        while (rx_count < target && n < max) begin
            step();
            n++;
        end
        check(tag, 32'(rx_count >= target), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fb"}, 32'(frontbuffer_select), 32'd0);
        check({tag, "_rclken"}, 32'(ebr_rclken), 32'd0);
        check({tag, "_raddr"}, 32'(ebr_raddr), 32'd0);
        check({tag, "_sel"}, 32'(ebr_read_select), 32'd0);
        check({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_flags"}, 32'({block_start, strip_last}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_dropped"}, 32'(dropped_strips), 32'd0);
    endtask

    initial begin
        int base;
        int cycles;
        logic exp_fb;

        // Reset
        nreset = 1'b0;
        step();
        step();
        check_reset_values("reset");
        exp_fb = 1'b0;
        nreset = 1'b1;
        step();

        // Single strip, pix_ready held high; latency and cycle count
        base = rx_count;
        push_strip();
        pulse_done();
        check("fb_before_toggle", 32'(frontbuffer_select), 32'd0);
        step();
        exp_fb = ~exp_fb;
        check("fb_toggled", 32'(frontbuffer_select), 32'(exp_fb));
        check("busy_rise", 32'(busy), 32'd1);
        check("first_rclken", 32'(ebr_rclken), 32'd1);
        check("first_raddr", 32'(ebr_raddr), 32'd0);
        check("first_sel", 32'(ebr_read_select), 32'd0);
        step();
        check("second_raddr", 32'(ebr_raddr), 32'd1);
        check("valid_n2", 32'(pix_valid), 32'd0);
        step();
        check("valid_n3", 32'(pix_valid), 32'd1);
        check("first_pixel", 32'({block_start, pix_data}), 32'({1'b1, mem_val(0, 0)}));
        cycles = 3;
        while (busy && cycles < 4000) begin
            step();
            cycles++;
        end
        check("strip_cycles", 32'(cycles), 32'd2563);
        check("strip1_count", 32'(rx_count - base), 32'd2560);
        check("strip1_queue", 32'(exp_q.size()), 32'd0);

        // Random backpressure
        base = rx_count;
        push_strip();
        rand_ready = 1'b1;
        pulse_done();
        exp_fb = ~exp_fb;
        step();
        wait_idle("rand_idle", 20000);
        rand_ready = 1'b0;
        pix_ready = 1'b1;
        check("rand_count", 32'(rx_count - base), 32'd2560);
        check("rand_queue", 32'(exp_q.size()), 32'd0);
        check("rand_fb", 32'(frontbuffer_select), 32'(exp_fb));

        // strip_done while streaming, at pixel 1000
        base = rx_count;
        push_strip();
        pulse_done();
        exp_fb = ~exp_fb;
        wait_rx("ovr_reach_1000", base + 1000, 3000);
        pulse_done();
        step();
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_dropped", 32'(dropped_strips), 32'd1);
        check("ovr_fb", 32'(frontbuffer_select), 32'(exp_fb));
        wait_idle("ovr_idle", 4000);
        check("ovr_count", 32'(rx_count - base), 32'd2560);
        check("ovr_queue", 32'(exp_q.size()), 32'd0);

        // Reset mid-strip, then restart from e=0, b=0
        push_strip();
        pulse_done();
        wait_rx("rst_reach_500", rx_count + 500, 3000);
        nreset = 1'b0;
        step();
        check_reset_values("midrst");
        exp_q.delete();
        exp_fb = 1'b0;
        nreset = 1'b1;
        step();
        base = rx_count;
        push_strip();
        pulse_done();
        exp_fb = ~exp_fb;
        step();
        wait_idle("restart_idle", 4000);
        check("restart_count", 32'(rx_count - base), 32'd2560);
        check("restart_queue", 32'(exp_q.size()), 32'd0);

        // strip_done coincident with the strip_last handshake
        base = rx_count;
        push_strip();
        pulse_done();
        exp_fb = ~exp_fb;
        cycles = 0;
        while (!(pix_valid && strip_last && pix_ready) && cycles < 4000) begin
            step();
            cycles++;
        end
        check("coin_found_last", 32'(pix_valid && strip_last), 32'd1);
        push_strip();
        pulse_done();
        exp_fb = ~exp_fb;
        step();
        check("coin_fb", 32'(frontbuffer_select), 32'(exp_fb));
        check("coin_busy", 32'(busy), 32'd1);
        check("coin_overrun", 32'(overrun), 32'd0);
        check("coin_count", 32'(rx_count - base), 32'd2560);
        wait_idle("coin_idle", 4000);
        check("coin_overrun_end", 32'(overrun), 32'd0);
        check("coin_dropped", 32'(dropped_strips), 32'd0);
        check("coin_queue", 32'(exp_q.size()), 32'd0);

        // 300 dropped strips with the output stalled
        pix_ready = 1'b0;
        push_strip();
        pulse_done();
        exp_fb = ~exp_fb;
        step();
        for (int i = 0; i < 300; i++) begin
            pulse_done();
            step();
            if (i == 9) check("sat_dropped_10", 32'(dropped_strips), 32'd10);
        end
        check("sat_dropped", 32'(dropped_strips), 32'd255);
        check("sat_overrun", 32'(overrun), 32'd1);
        check("sat_fb", 32'(frontbuffer_select), 32'(exp_fb));
        pix_ready = 1'b1;
        wait_idle("sat_idle", 4000);
        check("sat_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
